// File: rtl/video_pkg.sv
// Shared video types and default active geometry for the capture path and the
// receiver simulation model.
package video_pkg;

  localparam int H_ACTIVE_DEFAULT = 128;
  localparam int V_ACTIVE_DEFAULT = 32;
  localparam int RGB_W            = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ACTIVE
  } cap_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers the receiver's VS/DE/RGB once and derives the VS leading edge and
// the DE falling edge from a second delayed copy.
module sync_edge_detect
  import video_pkg::*;
#(
  parameter bit VS_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vs,
  input  logic de,
  input  rgb_t rgb,
  output logic de_q,
  output rgb_t rgb_q,
  output logic vs_lead,
  output logic de_fall
);

  logic vs_q;
  logic vs_qq;
  logic de_qq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
      de_q  <= 1'b0;
      de_qq <= 1'b0;
      rgb_q <= '0;
    end else begin
      vs_q  <= vs;
      vs_qq <= vs_q;
      de_q  <= de;
      de_qq <= de_q;
      rgb_q <= rgb;
    end
  end

  // The leading edge is the transition into the asserted VS level.
  assign vs_lead = VS_ACTIVE_HIGH ? (vs_q & ~vs_qq) : (~vs_q & vs_qq);
  assign de_fall = ~de_q & de_qq;

endmodule

// File: rtl/video_frame_capture.sv
// Locks onto VS, counts active pixels into (x,y) and writes them into a
// double-banked frame buffer, swapping banks only after a clean frame.
module video_frame_capture
  import video_pkg::*;
#(
  parameter int H_ACTIVE       = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE       = V_ACTIVE_DEFAULT,
  parameter int ADDR_W         = $clog2(H_ACTIVE * V_ACTIVE),
  parameter bit VS_ACTIVE_HIGH = 1'b1
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_enable,
  input  logic              I_vs,
  input  logic              I_de,
  input  logic [7:0]        I_r,
  input  logic [7:0]        I_g,
  input  logic [7:0]        I_b,
  output logic              O_wr_en,
  output logic [ADDR_W-1:0] O_wr_addr,
  output logic [RGB_W-1:0]  O_wr_data,
  output logic              O_wr_bank,
  output logic              O_frame_done,
  output logic              O_frame_err,
  output logic              O_busy
);

  localparam int X_W = $clog2(H_ACTIVE + 1);
  localparam int Y_W = $clog2(V_ACTIVE + 1);
  localparam logic [X_W-1:0] X_END  = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  cap_state_t     state;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  rgb_t           rgb_in;
  rgb_t           rgb_q;
  logic           de_q;
  logic           vs_lead;
  logic           de_fall;

  assign rgb_in = {I_r, I_g, I_b};

  sync_edge_detect #(
    .VS_ACTIVE_HIGH(VS_ACTIVE_HIGH)
  ) u_sync_edge_detect (
    .clk    (I_clk),
    .rst_n  (I_rst_n),
    .vs     (I_vs),
    .de     (I_de),
    .rgb    (rgb_in),
    .de_q   (de_q),
    .rgb_q  (rgb_q),
    .vs_lead(vs_lead),
    .de_fall(de_fall)
  );

  // A VS edge inside ACTIVE restarts the frame and outranks a coincident line end.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      O_wr_en      <= 1'b0;
      O_wr_addr    <= '0;
      O_wr_data    <= '0;
      O_wr_bank    <= 1'b0;
      O_frame_done <= 1'b0;
      O_frame_err  <= 1'b0;
    end else begin
      O_wr_en      <= 1'b0;
      O_frame_done <= 1'b0;
      O_frame_err  <= 1'b0;
      if (!I_enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (vs_lead) begin
              x     <= '0;
              y     <= '0;
              state <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (vs_lead) begin
              O_frame_err <= 1'b1;
              x           <= '0;
              y           <= '0;
            end else if (de_q) begin
              if (x == X_END) begin
                O_frame_err <= 1'b1;
                state       <= SYNC;
              end else begin
                O_wr_en   <= 1'b1;
                O_wr_addr <= ADDR_W'(32'(y) * 32'(H_ACTIVE) + 32'(x));
                O_wr_data <= rgb_q;
                x         <= x + 1'b1;
              end
            end else if (de_fall) begin
              if (x == X_END) begin
                x <= '0;
                y <= y + 1'b1;
                if (y == Y_LAST) begin
                  O_frame_done <= 1'b1;
                  O_wr_bank    <= ~O_wr_bank;
                  state        <= SYNC;
                end
              end else if (x != '0) begin
                O_frame_err <= 1'b1;
                state       <= SYNC;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign O_busy = (state == ACTIVE);

endmodule

// File: doc/video_frame_capture.md
Name: video_frame_capture

Overview:
- Sits directly downstream of the DVI receiver wrapper, in the recovered pixel-clock domain.
- Consumes the parallel RGB stream (VS/HS/DE/R/G/B), locks onto frame start, and counts active pixels into (x,y).
- Emits one write per active pixel into a double-banked frame buffer for the LED matrix tiles.
- Validates frame geometry, flags malformed frames, and toggles the bank only after a clean, complete frame.

Parameters:
- H_ACTIVE, 128, active pixels per line
- V_ACTIVE, 32, active lines per frame
- ADDR_W, $clog2(H_ACTIVE*V_ACTIVE) = 12, width of the write address
- VS_ACTIVE_HIGH, 1, 1: the VS leading edge is rising; 0: it is falling

Ports:
- I_clk  in  1  pixel clock (the receiver's RGB clock)
- I_rst_n  in  1  asynchronous active-low reset
- I_enable  in  1  capture enable
- I_vs  in  1  vertical sync from the receiver
- I_de  in  1  data enable from the receiver
- I_r / I_g / I_b  in  8 each  pixel colour
- O_wr_en  out  1  frame-buffer write strobe
- O_wr_addr  out  ADDR_W  equals y*H_ACTIVE + x
- O_wr_data  out  24  {r,g,b}
- O_wr_bank  out  1  bank being written; the consumer reads ~O_wr_bank
- O_frame_done  out  1  1-cycle pulse on a clean frame completion
- O_frame_err  out  1  1-cycle pulse on a geometry error
- O_busy  out  1  high in ACTIVE state

Behaviour:
- Reset values: all outputs 0, O_wr_bank=0, FSM=IDLE, x=y=0, input registers 0.
- Input stage: I_vs, I_de and RGB are registered once (vs_q, de_q, rgb_q). de_qq and vs_qq are delayed once more for edge detection.
- Write latency: a pixel sampled with I_de=1 on edge k drives O_wr_en=1 with its address and data after edge k+1. Outputs are registered.
- O_wr_addr and O_wr_data hold their last value when O_wr_en=0.
- VS leading edge = vs_q asserted && vs_qq deasserted, with polarity set by VS_ACTIVE_HIGH.
- FSM states: IDLE, SYNC, ACTIVE.
  - IDLE: entered at reset. If I_enable=1, go to SYNC.
  - SYNC: no writes. On a VS leading edge: x=0, y=0, go to ACTIVE.
  - ACTIVE:
    - While de_q=1 and x<H_ACTIVE: write the pixel, then x++.
    - Line end = de_q=0 && de_qq=1. If x==H_ACTIVE: x=0, y++.
    - If that line end makes y reach V_ACTIVE: pulse O_frame_done, toggle O_wr_bank (same edge), go to SYNC.
    - O_frame_done is therefore asserted in the cycle directly after the last O_wr_en.
- Errors (all abort: pulse O_frame_err, no bank toggle, no O_frame_done):
  - Long line: de_q=1 while x==H_ACTIVE. No write for that pixel. Go to SYNC.
  - Short line: a line end with 0<x<H_ACTIVE. Go to SYNC.
  - VS leading edge in ACTIVE before completion: pulse err, then treat the edge as a new frame start (x=y=0, stay in ACTIVE). This takes priority over a simultaneous line end.
- DE activity in SYNC (blanking lines after V_ACTIVE, or a partial frame seen after enable) is ignored.
- I_enable=0: go to IDLE on the next edge from any state. O_wr_en=0 from then on. No err or done pulse. O_wr_bank is retained.
- Width rules:
  - x is $clog2(H_ACTIVE+1) bits and y is $clog2(V_ACTIVE+1) bits; neither wraps.
  - The address is computed from the registered x/y; the multiply is done by the synthesizer with a constant operand.
- An asynchronous reset mid-frame returns everything to reset values immediately. The next capture requires a fresh VS edge.

Decomposition:
- Shared package video_pkg:
  - typedef rgb_t (struct: r, g, b as 8 bits each)
  - typedef enum cap_state_t {IDLE, SYNC, ACTIVE}
  - RGB_W = 24
  - The default H_ACTIVE/V_ACTIVE constants, also shared with the receiver simulation model.
- One natural sub-module: sync_edge_detect. It registers VS/DE and produces de_q, rgb_q, vs_lead and de_fall.
- The FSM and counters stay in video_frame_capture.

Test Plan:
- Reset, enable, two clean frames of 128x32 (H_TOTAL 144, V_TOTAL 40) -> 4096 writes per frame, addrs 0..4095 in order, O_wr_data equals stimulus with 2-cycle latency, O_frame_done pulses once per frame, O_wr_bank 0->1->0.
- A frame whose line 5 has 127 pixels -> O_frame_err pulse at that line end, no O_frame_done, bank unchanged, writes stop until the next VS edge; the next clean frame completes normally.
- A line with 130 pixels -> writes for x=0..127 only, O_frame_err pulse on the 129th pixel, abort to SYNC.
- VS leading edge after 10 lines -> O_frame_err pulse, the next DE writes addr 0, and the frame then completes with O_frame_done.
- Enable asserted mid-frame (line 12) -> no writes until the next VS edge; I_enable dropped mid-frame -> O_wr_en=0 next cycle, no pulses.
- I_rst_n asserted during line 3 -> all outputs 0 immediately; after release, capture waits for a VS edge.
